rv32_mem_arbiter: RTL and testbench
===================================

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1, meaning 1 = alternate grants on conflict and 0 = fixed data priority.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port instr_request, input, memory_request_t: the fetch requester; active when op != MEM_NOP.
REQ-005 SHALL have port instr_request_done, output, 1 bit: one-cycle completion pulse to fetch.
REQ-006 SHALL have port instr, output, rv32_word: read data for fetch, valid with instr_request_done.
REQ-007 SHALL have port data_request, input, memory_request_t: the load/store requester; active when op != MEM_NOP.
REQ-008 SHALL have port data_request_done, output, 1 bit: one-cycle completion pulse to the mem stage.
REQ-009 SHALL have port data, output, rv32_word: load data, valid with data_request_done.
REQ-010 SHALL have port mem_request, output, memory_request_t: the request to the shared single-port memory.
REQ-011 SHALL have port mem_ready, input, 1 bit: one-cycle pulse from memory when the current access completes.
REQ-012 SHALL have port mem_rdata, input, rv32_word: memory read data, valid with mem_ready.
REQ-013 SHALL have port instr_grants, output, 32 bits: count of completed fetch accesses.
REQ-014 SHALL have port data_grants, output, 32 bits: count of completed data accesses.

Function
REQ-015 SHALL implement the FSM states IDLE, BUSY_I and BUSY_D.
REQ-016 In IDLE with exactly one active requester, SHALL latch that request and enter the matching BUSY state on the next edge.
REQ-017 In IDLE with both requesters active and FAIR=0, SHALL grant data.
REQ-018 In IDLE with both requesters active and FAIR=1, SHALL grant the requester not granted by the previous conflict resolution; the first conflict after reset goes to data.
REQ-019 While in BUSY_x, SHALL drive mem_request from the latched copy (registered), so input changes during BUSY have no effect.
REQ-020 In IDLE, SHALL drive mem_request.op = MEM_NOP.
REQ-021 In BUSY_x, on mem_ready, SHALL on the next edge pulse the matching done signal for exactly 1 cycle, register mem_rdata to the matching read-data output, and return to IDLE.
REQ-022 SHALL hold each read-data output until that requester's next completion.
REQ-023 SHALL ignore mem_ready while in IDLE.
REQ-024 Latency: request active at edge t gives mem_request valid after t; mem_ready at edge k gives done valid after k; earliest next grant is at edge k+1, so there are no back-to-back memory cycles.
REQ-025 A request still active in the cycle its done pulse is asserted SHALL be treated as a new request; requesters drop or advance the request on done.
REQ-026 SHALL increment each grant counter by 1 per done pulse, wrapping modulo 2^32.
REQ-027 Stores SHALL complete identically to loads (done pulse on mem_ready); the read-data output is updated but its value is don't-care.

Reset
REQ-028 SHALL set, on reset high at an edge: state IDLE; mem_request.op MEM_NOP; both done signals 0; instr 0; data 0; both counters 0; fairness pointer to data.
REQ-029 Reset mid-access SHALL abort it, with no done pulse and no counter increment, and SHALL ignore any later mem_ready belonging to the aborted access.

Structure
REQ-030 memory_request_t, the MEM_NOP/MEM_LOAD/MEM_STORE op encoding and rv32_word SHALL come from the shared rv32_types package.
REQ-031 The arbiter state enum SHALL be added to the shared rv32_types package.
REQ-032 The block SHALL be a single module; the grant counter is a natural sub-module, rv32_event_counter, instantiated twice.

Verification
REQ-033 Single fetch: instr_request addr 0x100 LOAD; memory answers after 3 cycles with 0x00500093 -> one instr_request_done pulse, instr=0x00500093, instr_grants=1, data_request_done never asserted.
REQ-034 Conflict with FAIR=1: both requesters active continuously for 4 accesses -> grant order D, I, D, I, and each done aligned with its own mem_ready.
REQ-035 Conflict with FAIR=0: both requesters active for 3 accesses -> D, D, D, and instr_request_done stays 0 throughout.
REQ-036 Input change during BUSY: data_request addr changes 0x200 -> 0x300 mid-access -> mem_request addr stays 0x200 until completion.
REQ-037 Reset mid-access: reset asserted 1 cycle after grant, mem_ready arrives 2 cycles later -> no done pulse, counters 0, state IDLE, mem_request.op MEM_NOP.
REQ-038 Counter wrap: data_grants preloaded via force to 0xFFFFFFFF, then one store completes -> data_grants=0.

Source files
------------

// File: rtl/rv32_types_pkg.sv
// Shared RV32 core types: memory request bundle, op encoding, data word,
// and the memory arbiter state enum.
package rv32_types;

   typedef logic [31:0] rv32_word;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_op_t;

   typedef struct packed {
      mem_op_t  op;
      rv32_word addr;
      rv32_word wdata;
   } memory_request_t;

   localparam memory_request_t MEM_REQ_IDLE = '{op: MEM_NOP, addr: '0, wdata: '0};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rv32_event_counter.sv
// Free-running event counter: +1 per cycle with inc high, wraps modulo 2^WIDTH.
module rv32_event_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc)
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Arbitrates fetch and load/store requesters onto one single-port memory,
// one access in flight at a time, with registered request and completion.
module rv32_mem_arbiter
   import rv32_types::*;
#(
   parameter int FAIR = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  memory_request_t instr_request,
   output logic            instr_request_done,
   output rv32_word        instr,
   input  memory_request_t data_request,
   output logic            data_request_done,
   output rv32_word        data,
   output memory_request_t mem_request,
   input  logic            mem_ready,
   input  rv32_word        mem_rdata,
   output logic [31:0]     instr_grants,
   output logic [31:0]     data_grants
);

   arb_state_t state, next_state;
   logic instr_active, data_active;
   logic conflict, grant_i, grant_d, complete;
   logic prefer_instr;

   assign instr_active = (instr_request.op != MEM_NOP);
   assign data_active  = (data_request.op != MEM_NOP);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      conflict   = 1'b0;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (instr_active && data_active) begin
               conflict = 1'b1;
               if (FAIR != 0 && prefer_instr)
                  grant_i = 1'b1;
               else
                  grant_d = 1'b1;
            end else if (instr_active) begin
               grant_i = 1'b1;
            end else if (data_active) begin
               grant_d = 1'b1;
            end
            if (grant_i)
               next_state = BUSY_I;
            else if (grant_d)
               next_state = BUSY_D;
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // mem_request is the latched copy: loaded only on grant, cleared on
   // completion, so requester changes during an access never reach memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_request        <= MEM_REQ_IDLE;
         instr_request_done <= 1'b0;
         data_request_done  <= 1'b0;
         instr              <= '0;
         data               <= '0;
         prefer_instr       <= 1'b0;
      end else begin
         instr_request_done <= 1'b0;
         data_request_done  <= 1'b0;
         if (grant_i)
            mem_request <= instr_request;
         else if (grant_d)
            mem_request <= data_request;
         else if (complete)
            mem_request <= MEM_REQ_IDLE;
         if (complete && state == BUSY_I) begin
            instr_request_done <= 1'b1;
            instr              <= mem_rdata;
         end
         if (complete && state == BUSY_D) begin
            data_request_done <= 1'b1;
            data              <= mem_rdata;
         end
         if (conflict)
            prefer_instr <= ~prefer_instr;
      end
   end

   rv32_event_counter #(.WIDTH(32)) u_instr_grants (
      .clk   (clk),
      .reset (reset),
      .inc   (instr_request_done),
      .count (instr_grants)
   );

   rv32_event_counter #(.WIDTH(32)) u_data_grants (
      .clk   (clk),
      .reset (reset),
      .inc   (data_request_done),
      .count (data_grants)
   );

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: a fair and a fixed-priority instance share the
// requester inputs; each is held in reset while the other is exercised.
module tb_rv32_mem_arbiter;
   import rv32_types::*;

   typedef struct {
      bit       is_instr;
      bit       chk;
      rv32_word rdata;
   } exp_t;

   logic            clk;
   logic            reset_fair, reset_fixed;
   memory_request_t instr_request, data_request;
   logic            ready0, ready1;
   rv32_word        mem_rdata;

   logic            idone0, ddone0, idone1, ddone1;
   rv32_word        instr0, data0, instr1, data1;
   memory_request_t mreq0, mreq1;
   logic [31:0]     igr0, dgr0, igr1, dgr1;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t q0[$];
   exp_t q1[$];

   rv32_mem_arbiter #(.FAIR(1)) dut (
      .clk                (clk),
      .reset              (reset_fair),
      .instr_request      (instr_request),
      .instr_request_done (idone0),
      .instr              (instr0),
      .data_request       (data_request),
      .data_request_done  (ddone0),
      .data               (data0),
      .mem_request        (mreq0),
      .mem_ready          (ready0),
      .mem_rdata          (mem_rdata),
      .instr_grants       (igr0),
      .data_grants        (dgr0)
   );

   rv32_mem_arbiter #(.FAIR(0)) dut_fixed (
      .clk                (clk),
      .reset              (reset_fixed),
      .instr_request      (instr_request),
      .instr_request_done (idone1),
      .instr              (instr1),
      .data_request       (data_request),
      .data_request_done  (ddone1),
      .data               (data1),
      .mem_request        (mreq1),
      .mem_ready          (ready1),
      .mem_rdata          (mem_rdata),
      .instr_grants       (igr1),
      .data_grants        (dgr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every done pulse must match the oldest expected completion.
   always @(negedge clk) begin : mon0
      exp_t e;
      if (idone0 || ddone0) begin
         n_tests++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL mon0_unexpected_done: got idone=%0b ddone=%0b, expected no done", idone0, ddone0);
         end else begin
            e = q0.pop_front();
            if ((idone0 && ddone0) || (idone0 !== e.is_instr) ||
                (e.chk && ((e.is_instr ? instr0 : data0) !== e.rdata))) begin
               n_fail++;
               $display("FAIL mon0_done: got idone=%0b ddone=%0b instr=%h data=%h, expected instr_side=%0b rdata=%h",
                        idone0, ddone0, instr0, data0, e.is_instr, e.rdata);
            end
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (idone1 || ddone1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL mon1_unexpected_done: got idone=%0b ddone=%0b, expected no done", idone1, ddone1);
         end else begin
            e = q1.pop_front();
            if ((idone1 && ddone1) || (idone1 !== e.is_instr) ||
                (e.chk && ((e.is_instr ? instr1 : data1) !== e.rdata))) begin
               n_fail++;
               $display("FAIL mon1_done: got idone=%0b ddone=%0b instr=%h data=%h, expected instr_side=%0b rdata=%h",
                        idone1, ddone1, instr1, data1, e.is_instr, e.rdata);
            end
         end
      end
   end

   function automatic memory_request_t get_req(input int sel);
      return (sel == 0) ? mreq0 : mreq1;
   endfunction

   // Acts as the memory for one access: waits for the grant, checks the
   // request stays stable for lat cycles, pulses mem_ready, checks done side.
   task automatic serve(input int sel, input bit exp_instr, input mem_op_t exp_op,
                        input rv32_word exp_addr, input int lat, input rv32_word rdata);
      memory_request_t r;
      exp_t e;
      logic id, dd;
      int waited;
      waited = 0;
      r = get_req(sel);
      while (r.op == MEM_NOP && waited < 20) begin
         @(negedge clk);
         waited++;
         r = get_req(sel);
      end
      n_tests++;
      if (r.op !== exp_op || r.addr !== exp_addr) begin
         n_fail++;
         $display("FAIL serve_grant: got op=%0d addr=%h after %0d cycles, expected op=%0d addr=%h",
                  r.op, r.addr, waited, exp_op, exp_addr);
         return;
      end
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         r = get_req(sel);
         n_tests++;
         if (r.op !== exp_op || r.addr !== exp_addr) begin
            n_fail++;
            $display("FAIL serve_hold: got op=%0d addr=%h, expected op=%0d addr=%h", r.op, r.addr, exp_op, exp_addr);
         end
      end
      mem_rdata  = rdata;
      e.is_instr = exp_instr;
      e.chk      = (exp_op == MEM_LOAD);
      e.rdata    = rdata;
      if (sel == 0) begin
         ready0 = 1'b1;
         q0.push_back(e);
      end else begin
         ready1 = 1'b1;
         q1.push_back(e);
      end
      @(negedge clk);
      ready0 = 1'b0;
      ready1 = 1'b0;
      id = (sel == 0) ? idone0 : idone1;
      dd = (sel == 0) ? ddone0 : ddone1;
      r  = get_req(sel);
      n_tests++;
      if ({id, dd} !== (exp_instr ? 2'b10 : 2'b01) || r.op !== MEM_NOP) begin
         n_fail++;
         $display("FAIL serve_done_align: got idone=%0b ddone=%0b op=%0d, expected idone=%0b ddone=%0b op=0",
                  id, dd, r.op, exp_instr, !exp_instr);
      end
   endtask

   task automatic pulse_reset(input int sel);
      @(negedge clk);
      if (sel == 0) reset_fair = 1'b1; else reset_fixed = 1'b1;
      @(negedge clk);
      if (sel == 0) reset_fair = 1'b0; else reset_fixed = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (mreq0.op !== MEM_NOP || idone0 !== 1'b0 || ddone0 !== 1'b0 || instr0 !== 32'h0 ||
          data0 !== 32'h0 || igr0 !== 32'h0 || dgr0 !== 32'h0 || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got op=%0d id=%0b dd=%0b instr=%h data=%h igr=%h dgr=%h, expected all zero/NOP",
                  mreq0.op, idone0, ddone0, instr0, data0, igr0, dgr0);
      end
      reset_fair = 1'b0;
   endtask

   task automatic test_single_fetch();
      instr_request = '{op: MEM_LOAD, addr: 32'h100, wdata: '0};
      serve(0, 1'b1, MEM_LOAD, 32'h100, 3, 32'h0050_0093);
      instr_request = MEM_REQ_IDLE;
      @(negedge clk);
      n_tests++;
      if (instr0 !== 32'h0050_0093 || igr0 !== 32'd1 || dgr0 !== 32'd0) begin
         n_fail++;
         $display("FAIL single_fetch: got instr=%h igr=%0d dgr=%0d, expected instr=00500093 igr=1 dgr=0", instr0, igr0, dgr0);
      end
   endtask

   task automatic test_input_hold();
      data_request = '{op: MEM_LOAD, addr: 32'h200, wdata: '0};
      fork
         serve(0, 1'b0, MEM_LOAD, 32'h200, 4, 32'hCAFE_0200);
         begin
            @(negedge clk);
            @(negedge clk);
            data_request.addr = 32'h300;
         end
      join
      data_request = MEM_REQ_IDLE;
      @(negedge clk);
      n_tests++;
      if (data0 !== 32'hCAFE_0200 || instr0 !== 32'h0050_0093 || dgr0 !== 32'd1) begin
         n_fail++;
         $display("FAIL input_hold: got data=%h instr=%h dgr=%0d, expected data=cafe0200 instr=00500093 dgr=1",
                  data0, instr0, dgr0);
      end
   endtask

   task automatic test_idle_ready();
      mem_rdata = 32'hDEAD_BEEF;
      ready0 = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      @(negedge clk);
      n_tests++;
      if (dut.state !== IDLE || mreq0.op !== MEM_NOP || igr0 !== 32'd1 || dgr0 !== 32'd1 ||
          data0 !== 32'hCAFE_0200) begin
         n_fail++;
         $display("FAIL idle_ready: got state=%0d op=%0d igr=%0d dgr=%0d data=%h, expected IDLE NOP 1 1 cafe0200",
                  dut.state, mreq0.op, igr0, dgr0, data0);
      end
   endtask

   task automatic test_conflict_fair();
      pulse_reset(0);
      instr_request = '{op: MEM_LOAD, addr: 32'h400, wdata: '0};
      data_request  = '{op: MEM_LOAD, addr: 32'h500, wdata: '0};
      serve(0, 1'b0, MEM_LOAD, 32'h500, 1, 32'hD000_0001);
      serve(0, 1'b1, MEM_LOAD, 32'h400, 2, 32'hA000_0002);
      serve(0, 1'b0, MEM_LOAD, 32'h500, 1, 32'hD000_0003);
      serve(0, 1'b1, MEM_LOAD, 32'h400, 3, 32'hA000_0004);
      instr_request = MEM_REQ_IDLE;
      data_request  = MEM_REQ_IDLE;
      @(negedge clk);
      n_tests++;
      if (igr0 !== 32'd2 || dgr0 !== 32'd2 || instr0 !== 32'hA000_0004 || data0 !== 32'hD000_0003) begin
         n_fail++;
         $display("FAIL conflict_fair: got igr=%0d dgr=%0d instr=%h data=%h, expected 2 2 a0000004 d0000003",
                  igr0, dgr0, instr0, data0);
      end
   endtask

   task automatic test_reset_mid_access();
      pulse_reset(0);
      data_request = '{op: MEM_LOAD, addr: 32'h600, wdata: '0};
      @(negedge clk);
      n_tests++;
      if (mreq0.op !== MEM_LOAD || mreq0.addr !== 32'h600) begin
         n_fail++;
         $display("FAIL abort_grant: got op=%0d addr=%h, expected op=1 addr=00000600", mreq0.op, mreq0.addr);
      end
      reset_fair   = 1'b1;
      data_request = MEM_REQ_IDLE;
      @(negedge clk);
      reset_fair = 1'b0;
      @(negedge clk);
      mem_rdata = 32'hBAD0_0600;
      ready0    = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (dut.state !== IDLE || mreq0.op !== MEM_NOP || igr0 !== 32'd0 || dgr0 !== 32'd0 || data0 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid_access: got state=%0d op=%0d igr=%0d dgr=%0d data=%h, expected IDLE NOP 0 0 0",
                  dut.state, mreq0.op, igr0, dgr0, data0);
      end
   endtask

   task automatic test_counter_wrap();
      @(negedge clk);
      force dut.u_data_grants.count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.u_data_grants.count;
      @(negedge clk);
      n_tests++;
      if (dgr0 !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL wrap_preload: got dgr=%h, expected ffffffff", dgr0);
      end
      data_request = '{op: MEM_STORE, addr: 32'h700, wdata: 32'h1234_5678};
      serve(0, 1'b0, MEM_STORE, 32'h700, 2, 32'h0);
      data_request = MEM_REQ_IDLE;
      @(negedge clk);
      n_tests++;
      if (dgr0 !== 32'h0 || igr0 !== 32'h0) begin
         n_fail++;
         $display("FAIL counter_wrap: got dgr=%h igr=%h, expected 00000000 00000000", dgr0, igr0);
      end
   endtask

   task automatic test_conflict_fixed();
      reset_fair = 1'b1;
      pulse_reset(1);
      instr_request = '{op: MEM_LOAD, addr: 32'h800, wdata: '0};
      data_request  = '{op: MEM_LOAD, addr: 32'h900, wdata: '0};
      serve(1, 1'b0, MEM_LOAD, 32'h900, 1, 32'hF000_0001);
      serve(1, 1'b0, MEM_LOAD, 32'h900, 2, 32'hF000_0002);
      serve(1, 1'b0, MEM_LOAD, 32'h900, 1, 32'hF000_0003);
      instr_request = MEM_REQ_IDLE;
      data_request  = MEM_REQ_IDLE;
      @(negedge clk);
      n_tests++;
      if (igr1 !== 32'd0 || dgr1 !== 32'd3 || instr1 !== 32'h0 || data1 !== 32'hF000_0003) begin
         n_fail++;
         $display("FAIL conflict_fixed: got igr=%0d dgr=%0d instr=%h data=%h, expected 0 3 00000000 f0000003",
                  igr1, dgr1, instr1, data1);
      end
   endtask

   initial begin
      reset_fair    = 1'b1;
      reset_fixed   = 1'b1;
      instr_request = MEM_REQ_IDLE;
      data_request  = MEM_REQ_IDLE;
      ready0        = 1'b0;
      ready1        = 1'b0;
      mem_rdata     = '0;
      test_reset();
      test_single_fetch();
      test_input_hold();
      test_idle_ready();
      test_conflict_fair();
      test_reset_mid_access();
      test_counter_wrap();
      test_conflict_fixed();
      @(negedge clk);
      n_tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending completions, expected 0/0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
